// File: rtl/mem_bus_pkg.sv
// Shared field positions, FSM encoding and burst decode for the framebuffer bus responder.
// Pure declarations: no latency, no flow control.
package mem_bus_pkg;

  localparam int CTRL_WR_BIT    = 0;
  localparam int CTRL_BURST_LSB = 1;
  localparam int CTRL_BURST_MSB = 2;
  localparam int CTRL_WAIT_BIT  = 0;
  localparam int CTRL_PAR_BIT   = 1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RD_LAT  = 2'd1,
    ST_RD_BEAT = 2'd2,
    ST_WR_BEAT = 2'd3
  } state_e;

  function automatic logic [3:0] burst_len(input logic [1:0] code);
    return 4'd1 << code;
  endfunction

endpackage

// File: rtl/fb_ram.sv
// Single-port framebuffer RAM, one write or read per cycle.
// Registered read (data valid the cycle after the address); no backpressure.
module fb_ram #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 15
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem [0:(1<<ADDR_WIDTH)-1];
  logic [DATA_WIDTH-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) mem[addr_i] <= wdata_i;
    rdata_q <= mem[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/fb_mem_responder.sv
// Framebuffer bus slave: single/burst reads (first beat READ_LATENCY+1 cycles after start) and burst writes;
// ctrl_out[0] is the wait flag, bus_en low aborts. Optional read parity on ctrl_out[1] via FB_RESP_PARITY_EN.
module fb_mem_responder
  import mem_bus_pkg::*;
#(
  parameter int BUS_WIDTH    = 32,
  parameter int CTRL_WIDTH   = 8,
  parameter int DATA_WIDTH   = 16,
  parameter int ADDR_WIDTH   = 15,
  parameter int READ_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  reset_L,
  input  logic                  bus_en,
  input  logic [BUS_WIDTH-1:0]  bus_in,
  input  logic [CTRL_WIDTH-1:0] ctrl_in,
  output logic [CTRL_WIDTH-1:0] ctrl_out,
  output logic [BUS_WIDTH-1:0]  bus_out
);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [3:0]            beats_q, beats_d;
  logic [3:0]            lat_q, lat_d;
  logic                  ram_we;
  logic [DATA_WIDTH-1:0] ram_rdata;
  logic                  rd_beat;
  logic                  unused_bits;

  assign unused_bits = ^{bus_in[BUS_WIDTH-1:DATA_WIDTH], ctrl_in[CTRL_WIDTH-1:CTRL_BURST_MSB+1]};

  // addr_q is the next RAM address to issue; in reads it runs one ahead of the beat on bus_out.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    beats_d = beats_q;
    lat_d   = lat_q;
    ram_we  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus_en) begin
          addr_d  = bus_in[ADDR_WIDTH-1:0];
          beats_d = burst_len(ctrl_in[CTRL_BURST_MSB:CTRL_BURST_LSB]);
          if (ctrl_in[CTRL_WR_BIT]) begin
            state_d = ST_WR_BEAT;
          end else begin
            state_d = ST_RD_LAT;
            lat_d   = 4'(READ_LATENCY - 1);
          end
        end
      end
      ST_RD_LAT: begin
        if (!bus_en) begin
          state_d = ST_IDLE;
        end else if (lat_q == 4'd0) begin
          state_d = ST_RD_BEAT;
          addr_d  = addr_q + ADDR_WIDTH'(1);
        end else begin
          lat_d = lat_q - 4'd1;
        end
      end
      ST_RD_BEAT: begin
        if (!bus_en) begin
          state_d = ST_IDLE;
        end else begin
          addr_d  = addr_q + ADDR_WIDTH'(1);
          beats_d = beats_q - 4'd1;
          if (beats_q == 4'd1) state_d = ST_IDLE;
        end
      end
      ST_WR_BEAT: begin
        if (!bus_en) begin
          state_d = ST_IDLE;
        end else begin
          ram_we  = 1'b1;
          addr_d  = addr_q + ADDR_WIDTH'(1);
          beats_d = beats_q - 4'd1;
          if (beats_q == 4'd1) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      beats_q <= '0;
      lat_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      beats_q <= beats_d;
      lat_q   <= lat_d;
    end
  end

  fb_ram #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_ram (
    .clk_i  (clk),
    .we_i   (ram_we),
    .addr_i (addr_q),
    .wdata_i(bus_in[DATA_WIDTH-1:0]),
    .rdata_o(ram_rdata)
  );

  assign rd_beat = (state_q == ST_RD_BEAT);
  assign bus_out = rd_beat ? {{(BUS_WIDTH-DATA_WIDTH){1'b0}}, ram_rdata} : '0;

  always_comb begin
    ctrl_out                = '0;
    ctrl_out[CTRL_WAIT_BIT] = (state_q == ST_IDLE) || (state_q == ST_RD_LAT);
`ifdef FB_RESP_PARITY_EN
    ctrl_out[CTRL_PAR_BIT]  = rd_beat & (^ram_rdata);
`endif
  end

endmodule

// File: tb/tb_fb_mem_responder.sv
// Directed bench for fb_mem_responder: the driver schedules expected {ctrl_out, bus_out} per cycle
// into a scoreboard queue; a negedge monitor pops and compares them independently.
module tb_fb_mem_responder;

  logic        clk = 1'b0;
  logic        reset_L = 1'b1;
  logic        bus_en = 1'b0;
  logic [31:0] bus_in = '0;
  logic [7:0]  ctrl_in = '0;
  logic [7:0]  ctrl_out;
  logic [31:0] bus_out;

  typedef struct {
    int          cyc;
    logic [7:0]  ctrl;
    logic [31:0] bus;
  } exp_t;

  typedef logic [15:0] vec8_t [8];

  exp_t  sb[$];
  exp_t  e;
  vec8_t ev;
  int    cyc = 0;
  int    n_cmp = 0;
  int    n_err = 0;
  bit    hit;
  bit    done = 1'b0;

  fb_mem_responder #(
    .BUS_WIDTH(32), .CTRL_WIDTH(8), .DATA_WIDTH(16), .ADDR_WIDTH(15), .READ_LATENCY(2)
  ) dut (
    .clk     (clk),
    .reset_L (reset_L),
    .bus_en  (bus_en),
    .bus_in  (bus_in),
    .ctrl_in (ctrl_in),
    .ctrl_out(ctrl_out),
    .bus_out (bus_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] beat_ctrl(input logic [15:0] d);
`ifdef FB_RESP_PARITY_EN
    return {6'b0, ^d, 1'b0};
`else
    return 8'h00;
`endif
  endfunction

  task automatic expect_at(input int c, input logic [7:0] ctl, input logic [31:0] b);
    exp_t x;
    x.cyc = c; x.ctrl = ctl; x.bus = b;
    sb.push_back(x);
  endtask

  task automatic do_write(input logic [14:0] addr, input logic [1:0] code, input int n_drive,
                          input logic [15:0] base, input logic [15:0] step);
    int s;
    int len;
    len = 1 << code;
    @(posedge clk); #1;
    bus_en = 1'b1; bus_in = {17'b0, addr}; ctrl_in = {5'b0, code, 1'b1};
    s = cyc;
    expect_at(s, 8'h01, 32'h0);
    for (int i = 0; i < n_drive; i++) begin
      @(posedge clk); #1;
      bus_in = {16'h0, 16'(base + step * 16'(i))};
      expect_at(s + 1 + i, 8'h00, 32'h0);
    end
    @(posedge clk); #1;
    bus_en  = 1'b0;
    ctrl_in = 8'h00;
    bus_in  = {16'h0, 16'(base + step * 16'(n_drive))};
    if (n_drive < len) begin
      expect_at(s + 1 + n_drive, 8'h00, 32'h0);
      expect_at(s + 2 + n_drive, 8'h01, 32'h0);
    end else begin
      expect_at(s + 1 + n_drive, 8'h01, 32'h0);
    end
  endtask

  task automatic do_read(input logic [14:0] addr, input logic [1:0] code, input vec8_t exp_d);
    int s;
    int n;
    n = 1 << code;
    @(posedge clk); #1;
    bus_en = 1'b1; bus_in = {17'b0, addr}; ctrl_in = {5'b0, code, 1'b0};
    s = cyc;
    expect_at(s,     8'h01, 32'h0);
    expect_at(s + 1, 8'h01, 32'h0);
    expect_at(s + 2, 8'h01, 32'h0);
    for (int i = 0; i < n; i++)
      expect_at(s + 3 + i, beat_ctrl(exp_d[i]), {16'h0, exp_d[i]});
    expect_at(s + 3 + n, 8'h01, 32'h0);
    for (int i = 0; i < n + 3; i++) @(posedge clk);
    #1;
    bus_en  = 1'b0;
    ctrl_in = 8'h00;
  endtask

  initial begin
    #1 reset_L = 1'b0;
    @(posedge clk); #1;
    expect_at(cyc, 8'h01, 32'h0);
    @(posedge clk); #1;
    reset_L = 1'b1;

    // single write then read
    do_write(15'h0010, 2'd0, 1, 16'hA55A, 16'h0);
    ev = '{16'hA55A, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
    do_read(15'h0010, 2'd0, ev);

    // burst-4
    do_write(15'h0100, 2'd2, 4, 16'h1111, 16'h1111);
    ev = '{16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h0, 16'h0, 16'h0, 16'h0};
    do_read(15'h0100, 2'd2, ev);

    // burst-8 crossing the top of memory
    do_write(15'h7FFC, 2'd3, 8, 16'h7000, 16'h0001);
    ev = '{16'h7000, 16'h7001, 16'h7002, 16'h7003, 16'h7004, 16'h7005, 16'h7006, 16'h7007};
    do_read(15'h7FFC, 2'd3, ev);
    ev = '{16'h7004, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
    do_read(15'h0000, 2'd0, ev);

    // abort after two beats of a burst-8 write
    do_write(15'h0200, 2'd3, 8, 16'hB000, 16'h0001);
    do_write(15'h0200, 2'd3, 2, 16'hC000, 16'h0001);
    ev = '{16'hC000, 16'hC001, 16'hB002, 16'hB003, 16'hB004, 16'hB005, 16'hB006, 16'hB007};
    do_read(15'h0200, 2'd3, ev);

    // parity patterns (odd and even popcount)
    do_write(15'h0030, 2'd0, 1, 16'h0007, 16'h0);
    do_write(15'h0031, 2'd0, 1, 16'h0003, 16'h0);
    ev = '{16'h0007, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
    do_read(15'h0030, 2'd0, ev);
    ev = '{16'h0003, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
    do_read(15'h0031, 2'd0, ev);

    // asynchronous reset in the middle of a burst-4 read
    begin
      int s;
      @(posedge clk); #1;
      bus_en = 1'b1; bus_in = 32'h0000_0100; ctrl_in = 8'h04;
      s = cyc;
      expect_at(s,     8'h01, 32'h0);
      expect_at(s + 1, 8'h01, 32'h0);
      expect_at(s + 2, 8'h01, 32'h0);
      expect_at(s + 3, beat_ctrl(16'h1111), 32'h0000_1111);
      expect_at(s + 4, beat_ctrl(16'h2222), 32'h0000_2222);
      expect_at(s + 5, 8'h01, 32'h0);
      expect_at(s + 6, 8'h01, 32'h0);
      for (int i = 0; i < 5; i++) @(posedge clk);
      #1;
      reset_L = 1'b0;
      bus_en  = 1'b0;
      ctrl_in = 8'h00;
      repeat (2) @(posedge clk);
      #1 reset_L = 1'b1;
    end

    // idle after reset; RAM contents survive
    ev = '{16'hA55A, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
    do_read(15'h0010, 2'd0, ev);

    repeat (3) @(posedge clk);
    #1 done = 1'b1;
  end

  always @(negedge clk) begin
    hit = 1'b0;
    while (sb.size() > 0 && sb[0].cyc == cyc) begin
      e = sb.pop_front();
      hit = 1'b1;
      n_cmp++;
      if (ctrl_out !== e.ctrl || bus_out !== e.bus) begin
        n_err++;
        $display("FAIL cycle_%0d: actual ctrl_out=%02h bus_out=%08h, required ctrl_out=%02h bus_out=%08h",
                 cyc, ctrl_out, bus_out, e.ctrl, e.bus);
      end
    end
    if (!hit && reset_L && !ctrl_out[0] && bus_out != 32'h0) begin
      n_cmp++;
      n_err++;
      $display("FAIL unexpected_beat cycle_%0d: actual bus_out=%08h, required no read beat", cyc, bus_out);
    end
    if (done) begin
      n_cmp++;
      if (sb.size() != 0) begin
        n_err++;
        $display("FAIL scoreboard_drain: actual %0d entries left, required 0", sb.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual timeout, required bench completion");
    $fatal(1, "timeout");
  end

endmodule
